alu_issue_seq: RTL and testbench
================================

# alu_issue_seq

Multi-cycle issue sequencer that drives the ALU's `en`/`opcode`/`x1`/`x2` inputs and consumes its `y` result. It accepts one register-register instruction per handshake, reads both source operands from the register file, runs the ALU for one cycle, and writes the result back. It sits between instruction fetch/decode and the register file/ALU pair.

## Interface
- `DATA_W`, 32, operand/result width; must equal the ALU width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  sequencer can accept.
- `in_instr`  in  32  instruction word:
  - opcode [31:26], rd [25:21], rs1 [20:16], rs2 [15:11].
  - Bits [10:0] are ignored.
- `rf_re`  out  1  register-file read strobe; data is valid the next cycle.
- `rf_raddr1`, `rf_raddr2`  out  5  read addresses: rs1, rs2.
- `rf_rdata1`, `rf_rdata2`  in  DATA_W  read data.
- `rf_we`  out  1  write strobe.
- `rf_waddr`  out  5  write address (rd).
- `rf_wdata`  out  DATA_W  write data.
- `alu_en`  out  1  ALU enable.
- `alu_opcode`  out  6  ALU opcode.
- `alu_x1`, `alu_x2`  out  DATA_W  ALU operands.
- `alu_y`  in  DATA_W  ALU result (combinational).
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for an unsupported opcode.

## Operation
- States:
  - IDLE → RD: on `in_valid & in_ready` with a legal opcode.
  - IDLE → ILL: on `in_valid & in_ready` with an illegal opcode.
  - RD → OP → EX → WB → IDLE: unconditional.
  - ILL → IDLE: unconditional.
- `in_ready = (state == IDLE)`. The instruction is latched on acceptance; `in_instr` is don't-care afterwards.
- Legal opcodes: ADD 000100, SUB 000101, SHR 000110, SHL 000111, AND 001000, OR 001001, XOR 001010. All others are illegal.
- RD: `rf_re=1`, `rf_raddr1=rs1`, `rf_raddr2=rs2`.
- OP: capture `rf_rdata1` into operand A and `rf_rdata2` into operand B.
- EX:
  - Drive `alu_en=1`, `alu_opcode=op`, `alu_x2=A`, `alu_x1=B`, so the result is rs1 op rs2 (SUB = rs1 − rs2; shifts shift rs1 by rs2).
  - Capture `alu_y` into the result register at the end of EX.
- WB: `rf_we=1`, `rf_waddr=rd`, `rf_wdata=result`, `done=1`.
- ILL: `done=1`, `illegal=1`. No `rf_re`, `rf_we` or `alu_en` is issued for the instruction.
- Output registers:
  - `alu_opcode`, `alu_x1`, `alu_x2`, `rf_waddr`, `rf_wdata` are registered and hold their last value outside their active state.
  - `rf_re`, `rf_we`, `alu_en`, `done`, `illegal` are low outside their state.
- Result is full DATA_W, with no carry or flags. Arithmetic wraps modulo 2^DATA_W.
- rd == rs1 or rd == rs2 is legal; the write occurs after the reads.

## Timing
- Accept edge = cycle 0.
  - `rf_re` in cycle 1, `alu_en` in cycle 3, `rf_we`/`done` in cycle 4.
  - `in_ready` high again in cycle 5.
  - Peak throughput: one instruction per 5 cycles.
- Illegal instruction: `done`/`illegal` in cycle 1; `in_ready` in cycle 2.
- Reset values: state IDLE, `in_ready=1` after release; every other output 0.
- Reset mid-operation aborts immediately. No `rf_we` or `done` is produced for the aborted instruction.
- `rf_rdata*` must be valid exactly one cycle after `rf_re` (synchronous-read register file).

## Configuration
- `ALU_SEQ_ZERO_REG_EN` defined:
  - A source address of 0 yields operand 0 regardless of `rf_rdata*`.
  - rd == 0 suppresses `rf_we` in WB; `done` still pulses.
- Not defined: register 0 is an ordinary register for both reads and writes.

## Structure
- Shared package `alu_pkg`, imported by both this block and the ALU:
  - opcode localparams (ADD…XOR);
  - instruction field bit positions;
  - the state enum.
- One sub-module, `alu_seq_decode`: combinational field extraction and opcode legality check.

## Test plan
- r1=5, r2=3, ADD rd=4 → `rf_we` in cycle 4, `rf_waddr=4`, `rf_wdata=8`, `done` for 1 cycle.
- r1=3, r2=5, SUB rd=7 → `rf_wdata=0xFFFFFFFE`. r1=0xFFFFFFFF, r2=1, ADD → 0x00000000.
- r1=1, r2=31, SHL → 0x80000000. r1=0x80000000, r2=4, SHR → 0x08000000. r1=0xF0F0F0F0, r2=0xFF00FF00: AND → 0xF000F000, XOR → 0x0FF00FF0.
- Opcode 000000 → `done` and `illegal` in cycle 1; no `rf_re`/`rf_we`/`alu_en`; `in_ready` in cycle 2.
- ADD rd=0, rs1=0, rs2=2, `rf_rdata1=0xDEAD`, r2=1:
  - With macro: operand 0 and no `rf_we`.
  - Without macro: `rf_we` with `rf_waddr=0`, `rf_wdata=0xDEAE`.
- `rst_n` low during EX → all outputs 0 immediately. No `rf_we`/`done` follows. `in_ready=1` the first cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: opcodes, instruction field positions, sequencer states.
// Imported by the issue sequencer, its decoder and the ALU.
package alu_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;

  localparam logic [5:0] OP_ADD = 6'b000100;
  localparam logic [5:0] OP_SUB = 6'b000101;
  localparam logic [5:0] OP_SHR = 6'b000110;
  localparam logic [5:0] OP_SHL = 6'b000111;
  localparam logic [5:0] OP_AND = 6'b001000;
  localparam logic [5:0] OP_OR  = 6'b001001;
  localparam logic [5:0] OP_XOR = 6'b001010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_OP,
    S_EX,
    S_WB,
    S_ILL
  } seq_state_e;

  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL,
                      OP_AND, OP_OR, OP_XOR};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Field extraction and opcode legality for the ALU issue sequencer.
// Ports: instr in; op/rd/rs1/rs2 fields and legal flag out.
module alu_seq_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        legal
);

  // Low bits carry no information for register-register ops.
  logic unused_bits;
  assign unused_bits = ^instr[RS2_LSB-1:0];

  assign op    = instr[OP_MSB:OP_LSB];
  assign rd    = instr[RD_MSB:RD_LSB];
  assign rs1   = instr[RS1_MSB:RS1_LSB];
  assign rs2   = instr[RS2_MSB:RS2_LSB];
  assign legal = op_legal(op);

endmodule

// File: rtl/alu_issue_seq.sv
// Multi-cycle issue sequencer: RF read -> operand capture -> ALU -> writeback.
// Ports: in_* handshake, rf_* register file, alu_* ALU, done/illegal pulses.
// Option: ALU_SEQ_ZERO_REG_EN makes register 0 read as zero and ignore writes.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              rf_re,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              alu_en,
  output logic [5:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_x1,
  output logic [DATA_W-1:0] alu_x2,
  input  logic [DATA_W-1:0] alu_y,
  output logic              done,
  output logic              illegal
);

  seq_state_e state_q, state_d;

  logic [5:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [5:0]        alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_x1_q, alu_x1_d;
  logic [DATA_W-1:0] alu_x2_q, alu_x2_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic [5:0] dec_op;
  logic [4:0] dec_rd;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_legal;

  alu_seq_decode u_dec (
    .instr (in_instr),
    .op    (dec_op),
    .rd    (dec_rd),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .legal (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      alu_opcode_q <= '0;
      alu_x1_q     <= '0;
      alu_x2_q     <= '0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      alu_opcode_q <= alu_opcode_d;
      alu_x1_q     <= alu_x1_d;
      alu_x2_q     <= alu_x2_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = dec_legal ? S_RD : S_ILL;
      S_RD:   state_d = S_OP;
      S_OP:   state_d = S_EX;
      S_EX:   state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers. The ALU operand registers double as the
  // captured A/B operands; note A (rs1) goes to x2 and B (rs2) to x1.
  always_comb begin
    op_d         = op_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    alu_opcode_d = alu_opcode_q;
    alu_x1_d     = alu_x1_q;
    alu_x2_d     = alu_x2_q;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = dec_op;
          rd_d  = dec_rd;
          rs1_d = dec_rs1;
          rs2_d = dec_rs2;
        end
      end
      S_OP: begin
        alu_opcode_d = op_q;
`ifdef ALU_SEQ_ZERO_REG_EN
        alu_x2_d = (rs1_q == 5'd0) ? '0 : rf_rdata1;
        alu_x1_d = (rs2_q == 5'd0) ? '0 : rf_rdata2;
`else
        alu_x2_d = rf_rdata1;
        alu_x1_d = rf_rdata2;
`endif
      end
      S_EX: begin
        rf_wdata_d = alu_y;
        rf_waddr_d = rd_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    rf_re     = (state_q == S_RD);
    rf_raddr1 = rf_re ? rs1_q : 5'd0;
    rf_raddr2 = rf_re ? rs2_q : 5'd0;
    alu_en    = (state_q == S_EX);
`ifdef ALU_SEQ_ZERO_REG_EN
    rf_we     = (state_q == S_WB) && (rd_q != 5'd0);
`else
    rf_we     = (state_q == S_WB);
`endif
    done      = (state_q == S_WB) || (state_q == S_ILL);
    illegal   = (state_q == S_ILL);
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_x1     = alu_x1_q;
  assign alu_x2     = alu_x2_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a sync-read RF model and an ALU model.
// ALU model computes x2 op x1 (x2 carries rs1).
module tb_alu_issue_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic         rf_re;
  logic [4:0]   rf_raddr1;
  logic [4:0]   rf_raddr2;
  logic [W-1:0] rf_rdata1;
  logic [W-1:0] rf_rdata2;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [W-1:0] rf_wdata;
  logic         alu_en;
  logic [5:0]   alu_opcode;
  logic [W-1:0] alu_x1;
  logic [W-1:0] alu_x2;
  logic [W-1:0] alu_y;
  logic         done;
  logic         illegal;

  logic [W-1:0] rf [32];

  int total;
  int passed;

  alu_issue_seq #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .rf_re      (rf_re),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .alu_en     (alu_en),
    .alu_opcode (alu_opcode),
    .alu_x1     (alu_x1),
    .alu_x2     (alu_x2),
    .alu_y      (alu_y),
    .done       (done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_re) begin
      rf_rdata1 <= rf[rf_raddr1];
      rf_rdata2 <= rf[rf_raddr2];
    end
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  always_comb begin
    alu_y = '0;
    if (alu_en) begin
      case (alu_opcode)
        6'b000100: alu_y = alu_x2 + alu_x1;
        6'b000101: alu_y = alu_x2 - alu_x1;
        6'b000110: alu_y = alu_x2 >> alu_x1[4:0];
        6'b000111: alu_y = alu_x2 << alu_x1[4:0];
        6'b001000: alu_y = alu_x2 & alu_x1;
        6'b001001: alu_y = alu_x2 | alu_x1;
        6'b001010: alu_y = alu_x2 ^ alu_x1;
        default:   alu_y = '0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [5:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic exp_we,
                        input logic [W-1:0] exp_y);
    rf[rs1] = a;
    rf[rs2] = b;
    chk({tag, ".ready0"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = {op, rd, rs1, rs2, 11'h5A5};
    step();
    in_valid = 1'b0;
    in_instr = '1;
    chk({tag, ".c1.re"}, 32'(rf_re), 32'd1);
    chk({tag, ".c1.ra1"}, 32'(rf_raddr1), 32'(rs1));
    chk({tag, ".c1.ra2"}, 32'(rf_raddr2), 32'(rs2));
    chk({tag, ".c1.ready"}, 32'(in_ready), 32'd0);
    step();
    chk({tag, ".c2.re"}, 32'(rf_re), 32'd0);
    chk({tag, ".c2.en"}, 32'(alu_en), 32'd0);
    step();
    chk({tag, ".c3.en"}, 32'(alu_en), 32'd1);
    chk({tag, ".c3.opc"}, 32'(alu_opcode), 32'(op));
    chk({tag, ".c3.x2"}, alu_x2, xa);
    chk({tag, ".c3.x1"}, alu_x1, xb);
    chk({tag, ".c3.we"}, 32'(rf_we), 32'd0);
    step();
    chk({tag, ".c4.we"}, 32'(rf_we), 32'(exp_we));
    chk({tag, ".c4.waddr"}, 32'(rf_waddr), 32'(rd));
    chk({tag, ".c4.wdata"}, rf_wdata, exp_y);
    chk({tag, ".c4.done"}, 32'(done), 32'd1);
    chk({tag, ".c4.ill"}, 32'(illegal), 32'd0);
    chk({tag, ".c4.en"}, 32'(alu_en), 32'd0);
    step();
    chk({tag, ".c5.ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".c5.done"}, 32'(done), 32'd0);
    chk({tag, ".c5.we"}, 32'(rf_we), 32'd0);
    if (exp_we) chk({tag, ".rf"}, rf[rd], exp_y);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    #2;
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.re", 32'(rf_re), 32'd0);
    chk("rst.we", 32'(rf_we), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.x1", alu_x1, 32'd0);
    chk("rst.wdata", rf_wdata, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rel.ready", 32'(in_ready), 32'd1);
    chk("rel.en", 32'(alu_en), 32'd0);
    chk("rel.ill", 32'(illegal), 32'd0);

    run_op("add", 6'b000100, 5'd4, 5'd1, 5'd2,
           32'd5, 32'd3, 32'd5, 32'd3, 1'b1, 32'd8);
    run_op("sub", 6'b000101, 5'd7, 5'd1, 5'd2,
           32'd3, 32'd5, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE);
    run_op("addw", 6'b000100, 5'd5, 5'd1, 5'd2,
           32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0);
    run_op("shl", 6'b000111, 5'd6, 5'd1, 5'd2,
           32'd1, 32'd31, 32'd1, 32'd31, 1'b1, 32'h8000_0000);
    run_op("shr", 6'b000110, 5'd8, 5'd1, 5'd2,
           32'h8000_0000, 32'd4, 32'h8000_0000, 32'd4, 1'b1,
           32'h0800_0000);
    run_op("and", 6'b001000, 5'd10, 5'd11, 5'd12,
           32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0F0_F0F0,
           32'hFF00_FF00, 1'b1, 32'hF000_F000);
    run_op("xor", 6'b001010, 5'd13, 5'd11, 5'd12,
           32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0F0_F0F0,
           32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0);
    run_op("or", 6'b001001, 5'd14, 5'd11, 5'd12,
           32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0F0_F0F0,
           32'hFF00_FF00, 1'b1, 32'hFFF0_FFF0);
    run_op("rdeq", 6'b000100, 5'd3, 5'd3, 5'd2,
           32'd10, 32'd20, 32'd10, 32'd20, 1'b1, 32'd30);

    in_valid = 1'b1;
    in_instr = {6'b000000, 5'd9, 5'd1, 5'd2, 11'h000};
    step();
    in_valid = 1'b0;
    in_instr = '1;
    chk("ill.c1.done", 32'(done), 32'd1);
    chk("ill.c1.ill", 32'(illegal), 32'd1);
    chk("ill.c1.re", 32'(rf_re), 32'd0);
    chk("ill.c1.we", 32'(rf_we), 32'd0);
    chk("ill.c1.en", 32'(alu_en), 32'd0);
    chk("ill.c1.ready", 32'(in_ready), 32'd0);
    step();
    chk("ill.c2.ready", 32'(in_ready), 32'd1);
    chk("ill.c2.done", 32'(done), 32'd0);
    chk("ill.c2.ill", 32'(illegal), 32'd0);
    chk("ill.c2.wdata", rf_wdata, 32'd30);

`ifdef ALU_SEQ_ZERO_REG_EN
    run_op("zero", 6'b000100, 5'd0, 5'd0, 5'd2,
           32'hDEAD, 32'd1, 32'd0, 32'd1, 1'b0, 32'd1);
`else
    run_op("zero", 6'b000100, 5'd0, 5'd0, 5'd2,
           32'hDEAD, 32'd1, 32'hDEAD, 32'd1, 1'b1, 32'hDEAE);
`endif

    run_op("pre", 6'b001010, 5'd9, 5'd1, 5'd2,
           32'h1234_5678, 32'h0000_FFFF, 32'h1234_5678,
           32'h0000_FFFF, 1'b1, 32'h1234_A987);

    rf[1] = 32'd100;
    rf[2] = 32'd1;
    rf[12] = 32'h0BAD_0BAD;
    in_valid = 1'b1;
    in_instr = {6'b000100, 5'd12, 5'd1, 5'd2, 11'h000};
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort.c3.en", 32'(alu_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.en", 32'(alu_en), 32'd0);
    chk("abort.opc", 32'(alu_opcode), 32'd0);
    chk("abort.x1", alu_x1, 32'd0);
    chk("abort.x2", alu_x2, 32'd0);
    chk("abort.waddr", 32'(rf_waddr), 32'd0);
    chk("abort.wdata", rf_wdata, 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("abort.rel.ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("abort.post.we", 32'(rf_we), 32'd0);
      chk("abort.post.done", 32'(done), 32'd0);
      step();
    end
    chk("abort.rf12", rf[12], 32'h0BAD_0BAD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
